// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - valid/ready pipeline stage register with 2-entry skid buffer and bubble-safe flush
module pipe_stage_skid_reg #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [1:0]            occ_q;
  logic [DATA_WIDTH-1:0] main_data;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic                  accept;
  logic                  drain;
  logic                  load_main_in;
  logic                  load_main_skid;
  logic                  load_skid;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          next_state   = BUSY;
        end
      end
      BUSY: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (drain) begin
          next_state = EMPTY;
        end else if (accept) begin
          load_skid  = 1'b1;
          next_state = FULL;
        end
      end
      FULL: begin
        if (drain) begin
          load_main_skid = 1'b1;
          next_state     = BUSY;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // Status flags are registered from the next state so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else if (flush) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state       <= next_state;
      in_ready_q  <= (next_state != FULL);
      out_valid_q <= (next_state != EMPTY);
      occ_q       <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (!flush) begin
      if (load_main_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl & {CTRL_WIDTH{out_valid_q}};
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - directed and randomised checks of pipe_stage_skid_reg
module tb_pipe_stage_skid_reg;

  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic r);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [1:0] occ, input logic rdy);
    chk({tag, ".out_valid"}, DW'(out_valid), DW'(v));
    chk({tag, ".occupancy"}, DW'(occupancy), DW'(occ));
    chk({tag, ".in_ready"},  DW'(in_ready),  DW'(rdy));
  endtask

  logic [DW+CW-1:0] sb[$];
  logic [DW+CW-1:0] head;
  logic             acc;
  logic             drn;

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    #12;
    chk_state("reset", 1'b0, 2'd0, 1'b1);
    chk("reset.out_data", out_data, '0);
    chk("reset.out_ctrl", DW'(out_ctrl), '0);
    reset_n = 1'b1;
    step();

    // T1 streaming
    drive(1'b1, 64'h10, 4'h1, 1'b1); step();
    chk_state("t1.a", 1'b1, 2'd1, 1'b1);
    chk("t1.a.data", out_data, 64'h10);
    drive(1'b1, 64'h11, 4'h1, 1'b1); step();
    chk("t1.b.data", out_data, 64'h11);
    chk_state("t1.b", 1'b1, 2'd1, 1'b1);
    drive(1'b1, 64'h12, 4'h1, 1'b1); step();
    chk("t1.c.data", out_data, 64'h12);
    chk_state("t1.c", 1'b1, 2'd1, 1'b1);
    drive(1'b0, '0, '0, 1'b1); step();
    chk_state("t1.d", 1'b0, 2'd0, 1'b1);

    // T2 stall into skid
    drive(1'b1, 64'hA0, 4'h2, 1'b0); step();
    chk_state("t2.a", 1'b1, 2'd1, 1'b1);
    drive(1'b1, 64'hA1, 4'h3, 1'b0); step();
    chk_state("t2.b", 1'b1, 2'd2, 1'b0);
    chk("t2.b.data", out_data, 64'hA0);
    drive(1'b1, 64'hA2, 4'h4, 1'b0); step();
    chk_state("t2.c", 1'b1, 2'd2, 1'b0);
    chk("t2.c.data", out_data, 64'hA0);
    chk("t2.c.ctrl", DW'(out_ctrl), 64'h2);
    drive(1'b1, 64'hA2, 4'h4, 1'b1); step();
    chk_state("t2.d", 1'b1, 2'd1, 1'b1);
    chk("t2.d.data", out_data, 64'hA1);
    chk("t2.d.ctrl", DW'(out_ctrl), 64'h3);
    drive(1'b0, '0, '0, 1'b1); step();
    chk_state("t2.e", 1'b0, 2'd0, 1'b1);

    // T3 flush from FULL
    drive(1'b1, 64'h30, 4'hB, 1'b0); step();
    drive(1'b1, 64'h31, 4'hB, 1'b0); step();
    chk_state("t3.full", 1'b1, 2'd2, 1'b0);
    chk("t3.full.ctrl", DW'(out_ctrl), 64'hB);
    drive(1'b1, 64'hFF, 4'hB, 1'b1);
    flush = 1'b1; step();
    flush = 1'b0;
    chk_state("t3.flush", 1'b0, 2'd0, 1'b1);
    chk("t3.flush.ctrl", DW'(out_ctrl), '0);
    drive(1'b0, '0, '0, 1'b1); step();
    chk_state("t3.after", 1'b0, 2'd0, 1'b1);

    // T4 bubble gating on drain
    drive(1'b1, 64'h40, 4'hF, 1'b0); step();
    chk("t4.ctrl", DW'(out_ctrl), 64'hF);
    drive(1'b0, '0, '0, 1'b1); step();
    chk_state("t4.drain", 1'b0, 2'd0, 1'b1);
    chk("t4.drain.ctrl", DW'(out_ctrl), '0);

    // T5 asynchronous reset while FULL
    drive(1'b1, 64'h50, 4'h5, 1'b0); step();
    drive(1'b1, 64'h51, 4'h6, 1'b0); step();
    chk_state("t5.full", 1'b1, 2'd2, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk_state("t5.rst", 1'b0, 2'd0, 1'b1);
    chk("t5.rst.data", out_data, '0);
    chk("t5.rst.ctrl", DW'(out_ctrl), '0);
    drive(1'b0, '0, '0, 1'b0);
    step();
    reset_n = 1'b1;
    step();

    // T6 random handshakes against a FIFO scoreboard
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 4'($urandom), 1'($urandom_range(0, 2) != 0));
      chk("t6.occ", DW'(occupancy), DW'(sb.size()));
      chk("t6.valid", DW'(out_valid), DW'(sb.size() != 0));
      chk("t6.ready", DW'(in_ready), DW'(sb.size() < 2));
      chk("t6.ctrl_gate", DW'(out_ctrl & {CW{~out_valid}}), '0);
      acc = in_valid && (sb.size() < 2);
      drn = out_ready && (sb.size() != 0);
      if (drn) begin
        head = sb.pop_front();
        chk("t6.data", out_data, head[DW-1:0]);
        chk("t6.ctrl", DW'(out_ctrl), DW'(head[DW+CW-1:DW]));
      end
      if (acc) sb.push_back({in_ctrl, in_data});
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
